// File: rtl/string_pkg.sv
// Shared definitions for the string serializer slice.
// Holds the serializer state encoding and a constant-evaluable ceil(log2)
// helper used to size the length and slot-index fields.
package string_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Smallest r with 2**r >= value; used at elaboration time only.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/char_index_counter.sv
// Slot index counter for the string serializer.
// Loads a start index and a terminal index together, then steps up or down
// by one per enable. Once the index equals the terminal index further enables
// are ignored, so the counter can never wrap past the end of the string.
//
// Ports:
//   clock, reset_n   rising-edge clock, asynchronous active-low reset
//   load             capture load_idx / term_idx (has priority over enable)
//   load_idx         first slot to present
//   term_idx         last slot to present
//   enable           advance one slot
//   down             1 = decrement, 0 = increment
//   idx              current slot index
//   at_term          idx has reached the terminal slot
module char_index_counter
  import string_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [IDX_W-1:0] load_idx,
  input  logic [IDX_W-1:0] term_idx,
  input  logic             enable,
  input  logic             down,
  output logic [IDX_W-1:0] idx,
  output logic             at_term
);

  logic [IDX_W-1:0] term_q;

  assign at_term = (idx == term_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx    <= '0;
      term_q <= '0;
    end else if (load) begin
      idx    <= load_idx;
      term_q <= term_idx;
    end else if (enable && !at_term) begin
      idx <= down ? idx - 1'b1 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/string_serializer.sv
// String serializer: accepts a packed string of up to NCHARS characters and
// emits it one character per beat on a valid/ready stream.
//
// Ports:
//   clock, reset_n          rising-edge clock, asynchronous active-low reset
//   load_valid/load_ready   string request handshake (ready only in IDLE)
//   load_str                packed string, slot k = [k*CHAR_W +: CHAR_W]
//   load_len                valid slots counted from slot 0 (clamped to NCHARS)
//   out_valid/out_ready     character stream handshake
//   out_char                current character (0 when not sending)
//   out_last                beat carries the final slot in send order
//   busy                    high while sending
//   done                    one-cycle pulse when a string finishes
module string_serializer
  import string_pkg::*;
#(
  parameter  int CHAR_W    = 8,
  parameter  int NCHARS    = 11,
  parameter  int MSB_FIRST = 1,
  parameter  int SKIP_NUL  = 0,
  localparam int LEN_W     = clog2(NCHARS + 1)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [NCHARS*CHAR_W-1:0] load_str,
  input  logic [LEN_W-1:0]         load_len,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CHAR_W-1:0]        out_char,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
);

  localparam logic [LEN_W-1:0] NCHARS_L = LEN_W'(NCHARS);

  state_t                     state, state_nxt;
  logic                       armed;      // high from the first clock after reset release
  logic                       zero_done;  // delayed done for a zero-length request
  logic [NCHARS*CHAR_W-1:0]   str_p1;
  logic [LEN_W-1:0]           eff_len, start_idx, term_idx, idx;
  logic                       at_term, accept, advance, cur_nul;
  logic [CHAR_W-1:0]          cur_char;

  // Stage 0: request decode
  assign accept  = load_valid && load_ready;
  assign eff_len = (load_len > NCHARS_L) ? NCHARS_L : load_len;

  always_comb begin
    if (MSB_FIRST != 0) begin
      start_idx = eff_len - 1'b1;
      term_idx  = '0;
    end else begin
      start_idx = '0;
      term_idx  = eff_len - 1'b1;
    end
  end

  // Stage 1: captured string and slot index
  always_ff @(posedge clock) begin
    if (accept) str_p1 <= load_str;
  end

  char_index_counter #(
    .IDX_W (LEN_W)
  ) u_index (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (accept),
    .load_idx (start_idx),
    .term_idx (term_idx),
    .enable   (advance),
    .down     (MSB_FIRST != 0),
    .idx      (idx),
    .at_term  (at_term)
  );

  assign cur_char = str_p1[int'(idx)*CHAR_W +: CHAR_W];
  assign cur_nul  = (SKIP_NUL != 0) && (cur_char == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      armed     <= 1'b0;
      zero_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      armed     <= 1'b1;
      zero_done <= accept && (eff_len == '0);
    end
  end

  // A skipped NUL slot advances on its own; a real beat advances on out_ready.
  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    busy       = 1'b0;
    out_valid  = 1'b0;
    out_char   = '0;
    out_last   = 1'b0;
    advance    = 1'b0;
    done       = zero_done;
    case (state)
      ST_IDLE: begin
        load_ready = armed;
        if (load_valid && armed && (eff_len != '0)) state_nxt = ST_SEND;
      end
      ST_SEND: begin
        busy      = 1'b1;
        out_char  = cur_char;
        out_valid = !cur_nul;
        out_last  = !cur_nul && at_term;
        advance   = cur_nul || out_ready;
        if (advance && at_term) begin
          state_nxt = ST_IDLE;
          done      = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_string_serializer.sv
// Directed bench for string_serializer with a beat scoreboard.
// Three instances: A (NCHARS=11, MSB first), B (NCHARS=11, LSB first),
// C (NCHARS=3, LSB first, NUL skipping).
module tb_string_serializer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [2:0]  lv;
  logic [87:0] lstr;
  logic [3:0]  llen;
  logic        out_ready;

  logic       a_ready, a_valid, a_last, a_busy, a_done;
  logic [7:0] a_char;
  logic       b_ready, b_valid, b_last, b_busy, b_done;
  logic [7:0] b_char;
  logic       c_ready, c_valid, c_last, c_busy, c_done;
  logic [7:0] c_char;

  int         sel;
  logic       o_ready, o_valid, o_last, o_busy, o_done;
  logic [7:0] o_char;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] sb[$];  // {char, last}

  localparam logic [87:0] HELLO = "Hello World";

  always #5 clock = ~clock;

  string_serializer #(.CHAR_W(8), .NCHARS(11), .MSB_FIRST(1), .SKIP_NUL(0)) u_a (
    .clock(clock), .reset_n(reset_n), .load_valid(lv[0]), .load_ready(a_ready),
    .load_str(lstr), .load_len(llen), .out_valid(a_valid), .out_ready(out_ready),
    .out_char(a_char), .out_last(a_last), .busy(a_busy), .done(a_done));

  string_serializer #(.CHAR_W(8), .NCHARS(11), .MSB_FIRST(0), .SKIP_NUL(0)) u_b (
    .clock(clock), .reset_n(reset_n), .load_valid(lv[1]), .load_ready(b_ready),
    .load_str(lstr), .load_len(llen), .out_valid(b_valid), .out_ready(out_ready),
    .out_char(b_char), .out_last(b_last), .busy(b_busy), .done(b_done));

  string_serializer #(.CHAR_W(8), .NCHARS(3), .MSB_FIRST(0), .SKIP_NUL(1)) u_c (
    .clock(clock), .reset_n(reset_n), .load_valid(lv[2]), .load_ready(c_ready),
    .load_str(lstr[23:0]), .load_len(llen[1:0]), .out_valid(c_valid), .out_ready(out_ready),
    .out_char(c_char), .out_last(c_last), .busy(c_busy), .done(c_done));

  always_comb begin
    {o_ready, o_valid, o_last, o_busy, o_done, o_char} = {a_ready, a_valid, a_last, a_busy, a_done, a_char};
    if (sel == 1) {o_ready, o_valid, o_last, o_busy, o_done, o_char} = {b_ready, b_valid, b_last, b_busy, b_done, b_char};
    if (sel == 2) {o_ready, o_valid, o_last, o_busy, o_done, o_char} = {c_ready, c_valid, c_last, c_busy, c_done, c_char};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference order: slots L-1..0 (msb) or 0..L-1, NULs dropped when skipping.
  task automatic push_exp(input logic [87:0] s, input int len, input int nchars,
                          input bit msb, input bit skip);
    int L, k;
    logic [7:0] ch;
    L = (len > nchars) ? nchars : len;
    for (int n = 0; n < L; n++) begin
      k  = msb ? (L - 1 - n) : n;
      ch = s[k*8 +: 8];
      if (!(skip && ch == 8'h00)) sb.push_back({ch, n == L - 1});
    end
  endtask

  task automatic accept(input int which, input logic [87:0] s, input logic [3:0] l);
    @(negedge clock);
    sel = which;
    lv[which] = 1'b1;
    lstr = s;
    llen = l;
    #1;
    check("load_ready_idle", 32'(o_ready), 32'd1);
    @(posedge clock);
    #1;
    lv[which] = 1'b0;
    lstr = {24'($urandom), 32'($urandom), 32'($urandom)};
    llen = 4'($urandom);
  endtask

  // Runs until done (or stop_beats beats if nonzero); done_cyc is 1-based.
  task automatic drain(input int max_cyc, input logic [7:0] pat, input int pat_len,
                       input int stop_beats, output int done_cyc, output int nbeats,
                       output int gaps);
    logic       prev_stall, prev_last;
    logic [7:0] prev_char;
    logic [8:0] e;
    prev_stall = 1'b0;
    prev_char  = '0;
    prev_last  = 1'b0;
    done_cyc = 0;
    nbeats   = 0;
    gaps     = 0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clock);
      out_ready = (c < pat_len) ? pat[c] : 1'b1;
      #1;
      if (prev_stall) begin
        check("hold_valid", 32'(o_valid), 32'd1);
        check("hold_char", 32'(o_char), 32'(prev_char));
        check("hold_last", 32'(o_last), 32'(prev_last));
      end
      if (o_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 32'(o_char), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("beat_char", 32'(o_char), 32'(e[8:1]));
          check("beat_last", 32'(o_last), 32'(e[0]));
        end
        nbeats++;
      end else if (!o_valid) begin
        gaps++;
      end
      prev_stall = o_valid && !out_ready;
      prev_char  = o_char;
      prev_last  = o_last;
      if (o_done) begin
        lv = '0;
        done_cyc = c + 1;
        break;
      end
      if (stop_beats != 0 && nbeats == stop_beats) break;
    end
    if (stop_beats == 0) begin
      check("done_seen", 32'(done_cyc != 0), 32'd1);
      check("sb_empty", 32'(sb.size()), 32'd0);
      @(negedge clock);
      out_ready = 1'b1;
      #1;
      check("ready_after_done", 32'(o_ready), 32'd1);
      check("done_one_cycle", 32'(o_done), 32'd0);
      check("busy_after_done", 32'(o_busy), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d, n, g;
    logic [87:0] s;
    reset_n   = 1'b0;
    lv        = '0;
    lstr      = '0;
    llen      = '0;
    out_ready = 1'b0;
    sel       = 0;

    #12;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_char", 32'(o_char), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("ready_before_clock", 32'(o_ready), 32'd0);
    @(negedge clock);
    #1;
    check("ready_after_release", 32'(o_ready), 32'd1);

    // Hello World, highest slot first, back to back
    push_exp(HELLO, 11, 11, 1'b1, 1'b0);
    accept(0, HELLO, 4'd11);
    drain(40, 8'hFF, 0, 0, d, n, g);
    check("hello_msb_done_cyc", 32'(d), 32'd11);
    check("hello_msb_beats", 32'(n), 32'd11);
    check("hello_msb_gaps", 32'(g), 32'd0);

    // Lowest slot first, with load_valid held high during SEND
    push_exp(HELLO, 11, 11, 1'b0, 1'b0);
    accept(1, HELLO, 4'd11);
    lv[1] = 1'b1;
    #1;
    check("ready_in_send", 32'(o_ready), 32'd0);
    drain(40, 8'hFF, 0, 0, d, n, g);
    check("hello_lsb_done_cyc", 32'(d), 32'd11);
    check("hello_lsb_beats", 32'(n), 32'd11);

    // "22" with out_ready 1,0,0,1
    s = 88'h3232;
    push_exp(s, 2, 11, 1'b1, 1'b0);
    accept(0, s, 4'd2);
    drain(20, 8'b0000_1001, 4, 0, d, n, g);
    check("stall_done_cyc", 32'(d), 32'd4);
    check("stall_beats", 32'(n), 32'd2);

    // Zero length: done next cycle, no beat
    accept(0, HELLO, 4'd0);
    drain(10, 8'hFF, 0, 0, d, n, g);
    check("len0_done_cyc", 32'(d), 32'd1);
    check("len0_beats", 32'(n), 32'd0);

    // Over-long length clamps to NCHARS
    push_exp(HELLO, 15, 11, 1'b1, 1'b0);
    accept(0, HELLO, 4'd15);
    drain(40, 8'hFF, 0, 0, d, n, g);
    check("len15_done_cyc", 32'(d), 32'd11);
    check("len15_beats", 32'(n), 32'd11);

    // NUL skipping: {'A', 0, 'B'}
    s = {64'h0, "B", 8'h00, "A"};
    push_exp(s, 3, 3, 1'b0, 1'b1);
    accept(2, s, 4'd3);
    drain(20, 8'hFF, 0, 0, d, n, g);
    check("skip_done_cyc", 32'(d), 32'd3);
    check("skip_beats", 32'(n), 32'd2);
    check("skip_gaps", 32'(g), 32'd1);

    // Final slot NUL: no out_last anywhere, done still pulses
    s = {64'h0, 8'h00, "B", "A"};
    push_exp(s, 3, 3, 1'b0, 1'b1);
    accept(2, s, 4'd3);
    drain(20, 8'hFF, 0, 0, d, n, g);
    check("tailnul_done_cyc", 32'(d), 32'd3);
    check("tailnul_beats", 32'(n), 32'd2);

    // Reset after the third beat of Hello World
    push_exp(HELLO, 11, 11, 1'b1, 1'b0);
    accept(0, HELLO, 4'd11);
    drain(20, 8'hFF, 0, 3, d, n, g);
    check("pre_reset_beats", 32'(n), 32'd3);
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_valid", 32'(o_valid), 32'd0);
    check("midrst_done", 32'(o_done), 32'd0);
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_last", 32'(o_last), 32'd0);
    check("midrst_char", 32'(o_char), 32'd0);
    check("midrst_ready", 32'(o_ready), 32'd0);
    sb.delete();
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("postrst_valid", 32'(o_valid), 32'd0);
    check("postrst_done", 32'(o_done), 32'd0);
    @(negedge clock);
    #1;
    check("postrst_ready", 32'(o_ready), 32'd1);

    s = 88'h31;
    push_exp(s, 1, 11, 1'b1, 1'b0);
    accept(0, s, 4'd1);
    drain(10, 8'hFF, 0, 0, d, n, g);
    check("one_done_cyc", 32'(d), 32'd1);
    check("one_beats", 32'(n), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/string_serializer.md
STRING_SERIALIZER -- requirements
Module: string_serializer

Interface
REQ-001 SHALL have parameter CHAR_W, default 8, bits per character.
REQ-002 SHALL have parameter NCHARS, default 11, maximum characters per string (>=1).
REQ-003 SHALL have parameter MSB_FIRST, default 1; 1 = highest character slot sent first (Verilog string-literal order), 0 = lowest first.
REQ-004 SHALL have parameter SKIP_NUL, default 0; 1 = characters equal to zero produce no output beat.
REQ-005 SHALL define LEN_W = clog2(NCHARS+1).
REQ-006 clock  input  1  single clock; all state changes on its rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 load_valid  input  1  string request present.
REQ-009 load_ready  output  1  serializer can accept a string.
REQ-010 load_str  input  NCHARS*CHAR_W  packed string, slot k = bits [k*CHAR_W +: CHAR_W].
REQ-011 load_len  input  LEN_W  number of valid slots, counted from slot 0.
REQ-012 out_valid  output  1  out_char valid.
REQ-013 out_ready  input  1  sink accepts beat.
REQ-014 out_char  output  CHAR_W  current character.
REQ-015 out_last  output  1  beat carries slot index load_len-1 in send order.
REQ-016 busy  output  1  high in SEND state.
REQ-017 done  output  1  one-cycle pulse when a string finishes.

Function
REQ-018 SHALL implement states IDLE and SEND.
REQ-019 IDLE: load_ready=1; load accepted when load_valid&&load_ready.
REQ-020 On acceptance SHALL capture load_str and effective length L = min(load_len, NCHARS); load_str changes afterwards SHALL have no effect.
REQ-021 L=0: SHALL stay in IDLE, pulse done next cycle, emit no beat.
REQ-022 L>0: SHALL enter SEND; first out_valid in the cycle after acceptance (latency 1).
REQ-023 Send order: MSB_FIRST=1 -> slots L-1 down to 0; MSB_FIRST=0 -> slots 0 up to L-1.
REQ-024 A beat completes when out_valid&&out_ready; out_char/out_valid/out_last SHALL hold stable while out_valid&&!out_ready.
REQ-025 SHALL emit back-to-back beats (one per cycle) while out_ready stays high.
REQ-026 SKIP_NUL=1: zero slot SHALL consume one cycle with out_valid=0 and advance without waiting for out_ready.
REQ-027 After the final slot completes or is skipped: return to IDLE and pulse done in that same cycle; load_ready=1 next cycle.
REQ-028 load_ready SHALL be 0 throughout SEND; load_valid in SEND SHALL be ignored.
REQ-029 out_last with skipped final NUL: no beat carries out_last; done still pulses.
REQ-030 Slot index counter SHALL never wrap; index outside 0..L-1 SHALL never be presented.

Reset
REQ-031 reset_n low SHALL immediately force IDLE, out_valid=0, out_char=0, out_last=0, busy=0, done=0, load_ready=0 while asserted, 1 after first clock following deassertion.
REQ-032 Reset mid-string SHALL abandon the string; no done pulse, no further beats.

Structure
REQ-033 State enum and clog2 helper SHALL reside in shared package string_pkg.
REQ-034 Slot index up/down counter SHALL be sub-module char_index_counter (load, enable, direction, terminal flag); no other sub-modules.

Verification
REQ-035 "Hello World", NCHARS=11, load_len=11, MSB_FIRST=1, out_ready=1 -> 'H','e','l','l','o',' ','W','o','r','l','d' on 11 consecutive cycles, out_last on 'd', done with 'd'.
REQ-036 Same string, MSB_FIRST=0 -> 'd' first, 'H' last with out_last.
REQ-037 "22" (NCHARS=2), out_ready toggled 1,0,0,1 -> first '2' accepted cycle 1, second '2' held stable two cycles, accepted cycle 4.
REQ-038 load_len=0 -> no out_valid, done one cycle after acceptance; load_len=15 with NCHARS=11 -> exactly 11 beats.
REQ-039 SKIP_NUL=1, slots {'A',0,'B'} MSB_FIRST=0 -> beats 'A','B', one gap cycle, out_last on 'B'.
REQ-040 reset_n low after 3rd beat of "Hello World" -> out_valid 0 immediately, no done; new "1" load after release -> single '1' beat with out_last.
